// File: rtl/operand_fetch_if.sv
// ============================================================================
//  Module      : operand_fetch_if
//  Description : Signal bundle between the operand-fetch stage and its
//                neighbours (fetch, register file, EX/MEM/WB stages).
//                master = surrounding pipeline, slave = operand_fetch.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface operand_fetch_if;
    // Fetch side
    logic        InstrValid;
    logic [31:0] Instr;
    logic        Stall;
    logic        Flush;
    // Register file read ports
    logic [4:0]  RsAddr;
    logic [4:0]  RtAddr;
    logic [31:0] RsData;
    logic [31:0] RtData;
    // Forwarding sources
    logic [31:0] ExResult;
    logic        MemRegWrite;
    logic [4:0]  MemDest;
    logic [31:0] MemResult;
    logic        WbRegWrite;
    logic [4:0]  WbDest;
    logic [31:0] WbData;
    // ID/EX register contents
    logic        OpValid;
    logic [31:0] OpA;
    logic [31:0] OpB;
    logic [4:0]  OpDest;
    logic        OpRegWrite;
    logic        OpMemRead;
    logic [31:0] OpInstr;

    modport master (
        output InstrValid, Instr, Flush,
        output RsData, RtData,
        output ExResult, MemRegWrite, MemDest, MemResult,
        output WbRegWrite, WbDest, WbData,
        input  Stall, RsAddr, RtAddr,
        input  OpValid, OpA, OpB, OpDest, OpRegWrite, OpMemRead, OpInstr
    );

    modport slave (
        input  InstrValid, Instr, Flush,
        input  RsData, RtData,
        input  ExResult, MemRegWrite, MemDest, MemResult,
        input  WbRegWrite, WbDest, WbData,
        output Stall, RsAddr, RtAddr,
        output OpValid, OpA, OpB, OpDest, OpRegWrite, OpMemRead, OpInstr
    );
endinterface

`default_nettype wire

// File: rtl/operand_fetch.sv
// ============================================================================
//  Module      : operand_fetch
//  Description : Decode / operand-fetch stage. Drives the register file read
//                addresses, forwards results from EX/MEM/WB, detects load-use
//                hazards and loads the ID/EX pipeline register.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module operand_fetch (
    input  wire logic       Clk,
    input  wire logic       Reset,
    operand_fetch_if.slave  bus
);

    // ------------------------------------------------------------------------
    // Opcode / funct encodings
    // ------------------------------------------------------------------------
    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_JAL   = 6'h03;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_FN_JR    = 6'h08;
    localparam logic [4:0] c_REG_RA   = 5'd31;
    localparam logic [4:0] c_REG_ZERO = 5'd0;

    // ------------------------------------------------------------------------
    // Instruction fields
    // ------------------------------------------------------------------------
    logic [5:0] w_opcode;
    logic [4:0] w_rs;
    logic [4:0] w_rt;
    logic [4:0] w_rd;
    logic [5:0] w_funct;

    assign w_opcode = bus.Instr[31:26];
    assign w_rs     = bus.Instr[25:21];
    assign w_rt     = bus.Instr[20:16];
    assign w_rd     = bus.Instr[15:11];
    assign w_funct  = bus.Instr[5:0];

    // Register file read addresses are a straight slice of the instruction
    assign bus.RsAddr = w_rs;
    assign bus.RtAddr = w_rt;

    // ------------------------------------------------------------------------
    // ID/EX pipeline register
    // ------------------------------------------------------------------------
    logic        op_valid_q,    op_valid_d;
    logic        op_regwrite_q, op_regwrite_d;
    logic        op_memread_q,  op_memread_d;
    logic [4:0]  op_dest_q,     op_dest_d;
    logic [31:0] op_a_q,        op_a_d;
    logic [31:0] op_b_q,        op_b_d;
    logic [31:0] op_instr_q,    op_instr_d;

    // ------------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------------
    logic [4:0] w_dec_dest;
    logic       w_dec_regwrite;
    logic       w_dec_memread;

    // Destination register and write/load flags from opcode and funct
    always_comb begin
        w_dec_dest     = c_REG_ZERO;
        w_dec_regwrite = 1'b0;
        w_dec_memread  = 1'b0;
        case (w_opcode)
            c_OP_RTYPE: begin
                w_dec_dest     = w_rd;
                w_dec_regwrite = (w_funct != c_FN_JR);
            end
            6'h08, 6'h09, 6'h0A, 6'h0B,
            6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
                w_dec_dest     = w_rt;
                w_dec_regwrite = 1'b1;
            end
            c_OP_LW: begin
                w_dec_dest     = w_rt;
                w_dec_regwrite = 1'b1;
                w_dec_memread  = 1'b1;
            end
            c_OP_JAL: begin
                w_dec_dest     = c_REG_RA;
                w_dec_regwrite = 1'b1;
            end
            default: begin
                w_dec_dest     = c_REG_ZERO;
                w_dec_regwrite = 1'b0;
            end
        endcase
        // $0 is hardwired, so a write to it is a no-op
        if (w_dec_dest == c_REG_ZERO) begin
            w_dec_regwrite = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Forwarding
    // ------------------------------------------------------------------------
    // An instruction in ID/EX can only forward if its result is an ALU value;
    // a load's data is not available until MEM, which the stall covers.
    logic w_ex_fwd_en;
    assign w_ex_fwd_en = op_valid_q & op_regwrite_q & ~op_memread_q;

    // Select the newest producer of addr, nearest stage first. WB is needed
    // because the regfile write and this read happen on the same edge.
    function automatic logic [31:0] f_forward(
        input logic [4:0]  addr,
        input logic [31:0] rf_data,
        input logic        ex_en,
        input logic [4:0]  ex_dest,
        input logic [31:0] ex_data,
        input logic        mem_en,
        input logic [4:0]  mem_dest,
        input logic [31:0] mem_data,
        input logic        wb_en,
        input logic [4:0]  wb_dest,
        input logic [31:0] wb_data
    );
        logic [31:0] result;
        if (addr == 5'd0) begin
            result = 32'd0;
        end else if (ex_en && (ex_dest == addr)) begin
            result = ex_data;
        end else if (mem_en && (mem_dest == addr)) begin
            result = mem_data;
        end else if (wb_en && (wb_dest == addr)) begin
            result = wb_data;
        end else begin
            result = rf_data;
        end
        return result;
    endfunction

    logic [31:0] w_fwd_a;
    logic [31:0] w_fwd_b;

    // Forwarded values for both source operands
    always_comb begin
        w_fwd_a = f_forward(w_rs, bus.RsData,
                            w_ex_fwd_en, op_dest_q, bus.ExResult,
                            bus.MemRegWrite, bus.MemDest, bus.MemResult,
                            bus.WbRegWrite, bus.WbDest, bus.WbData);
        w_fwd_b = f_forward(w_rt, bus.RtData,
                            w_ex_fwd_en, op_dest_q, bus.ExResult,
                            bus.MemRegWrite, bus.MemDest, bus.MemResult,
                            bus.WbRegWrite, bus.WbDest, bus.WbData);
    end

    // ------------------------------------------------------------------------
    // Load-use hazard
    // ------------------------------------------------------------------------
    // rt is compared even when the ID instruction only reads rs; the extra
    // stall on I-types is harmless and keeps the comparator simple.
    logic w_hazard;
    assign w_hazard = bus.InstrValid & op_valid_q & op_memread_q
                    & (op_dest_q != c_REG_ZERO)
                    & ((op_dest_q == w_rs) | (op_dest_q == w_rt));

    // A flush discards the ID instruction, so there is nothing to hold
    assign bus.Stall = w_hazard & ~bus.Flush;

    // ------------------------------------------------------------------------
    // ID/EX next state
    // ------------------------------------------------------------------------
    // Load a decoded instruction or a bubble; bubbles keep the data fields
    always_comb begin
        op_valid_d    = 1'b0;
        op_regwrite_d = 1'b0;
        op_memread_d  = 1'b0;
        op_dest_d     = op_dest_q;
        op_a_d        = op_a_q;
        op_b_d        = op_b_q;
        op_instr_d    = op_instr_q;
        if (!bus.Flush && !w_hazard && bus.InstrValid) begin
            op_valid_d    = 1'b1;
            op_regwrite_d = w_dec_regwrite;
            op_memread_d  = w_dec_memread;
            op_dest_d     = w_dec_dest;
            op_a_d        = w_fwd_a;
            op_b_d        = w_fwd_b;
            op_instr_d    = bus.Instr;
        end
    end

    // ID/EX register with asynchronous clear
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            op_valid_q    <= 1'b0;
            op_regwrite_q <= 1'b0;
            op_memread_q  <= 1'b0;
            op_dest_q     <= 5'd0;
            op_a_q        <= 32'd0;
            op_b_q        <= 32'd0;
            op_instr_q    <= 32'd0;
        end else begin
            op_valid_q    <= op_valid_d;
            op_regwrite_q <= op_regwrite_d;
            op_memread_q  <= op_memread_d;
            op_dest_q     <= op_dest_d;
            op_a_q        <= op_a_d;
            op_b_q        <= op_b_d;
            op_instr_q    <= op_instr_d;
        end
    end

    assign bus.OpValid    = op_valid_q;
    assign bus.OpRegWrite = op_regwrite_q;
    assign bus.OpMemRead  = op_memread_q;
    assign bus.OpDest     = op_dest_q;
    assign bus.OpA        = op_a_q;
    assign bus.OpB        = op_b_q;
    assign bus.OpInstr    = op_instr_q;

endmodule

`default_nettype wire

// File: tb/tb_operand_fetch.sv
// ============================================================================
//  Module      : tb_operand_fetch
//  Description : Directed self-checking bench for operand_fetch.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_operand_fetch;

    logic Clk;
    logic Reset;
    int   n_cmp;
    int   n_err;

    operand_fetch_if bus ();

    operand_fetch dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Advance one rising edge and settle
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic quiet_fwd();
        bus.MemRegWrite = 1'b0;
        bus.MemDest     = 5'd0;
        bus.MemResult   = 32'd0;
        bus.WbRegWrite  = 1'b0;
        bus.WbDest      = 5'd0;
        bus.WbData      = 32'd0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        Reset = 1'b1;
        bus.InstrValid = 1'b0;
        bus.Instr      = 32'd0;
        bus.Flush      = 1'b0;
        bus.RsData     = 32'd0;
        bus.RtData     = 32'd0;
        bus.ExResult   = 32'd0;
        quiet_fwd();

        // Reset state
        step();
        step();
        chk("rst_valid", {31'd0, bus.OpValid}, 32'd0);
        chk("rst_opa",   bus.OpA, 32'd0);
        chk("rst_stall", {31'd0, bus.Stall}, 32'd0);
        Reset = 1'b0;

        // add $3,$1,$2 from the regfile
        bus.InstrValid = 1'b1;
        bus.Instr  = 32'h0022_1820;
        bus.RsData = 32'h10;
        bus.RtData = 32'h20;
        #1;
        chk("addr_rs", {27'd0, bus.RsAddr}, 32'd1);
        chk("addr_rt", {27'd0, bus.RtAddr}, 32'd2);
        step();
        chk("add_valid", {31'd0, bus.OpValid}, 32'd1);
        chk("add_opa",   bus.OpA, 32'h10);
        chk("add_opb",   bus.OpB, 32'h20);
        chk("add_dest",  {27'd0, bus.OpDest}, 32'd3);
        chk("add_rw",    {31'd0, bus.OpRegWrite}, 32'd1);
        chk("add_instr", bus.OpInstr, 32'h0022_1820);

        // sub $4,$3,$3: EX forward beats a MEM match on $3
        bus.Instr       = 32'h0063_2022;
        bus.RsData      = 32'h99;
        bus.RtData      = 32'h99;
        bus.ExResult    = 32'h7;
        bus.MemRegWrite = 1'b1;
        bus.MemDest     = 5'd3;
        bus.MemResult   = 32'h55;
        step();
        chk("exfwd_opa",  bus.OpA, 32'h7);
        chk("exfwd_opb",  bus.OpB, 32'h7);
        chk("exfwd_dest", {27'd0, bus.OpDest}, 32'd4);

        // add $6,$5,$0: MEM beats WB; $0 read gives zero
        bus.Instr       = 32'h00A0_3020;
        bus.RsData      = 32'h33;
        bus.RtData      = 32'h77;
        bus.MemRegWrite = 1'b1;
        bus.MemDest     = 5'd5;
        bus.MemResult   = 32'hAA;
        bus.WbRegWrite  = 1'b1;
        bus.WbDest      = 5'd5;
        bus.WbData      = 32'hBB;
        step();
        chk("prio_opa", bus.OpA, 32'hAA);
        chk("prio_opb", bus.OpB, 32'h0);

        // add $0,$1,$2: write to $0 is suppressed
        quiet_fwd();
        bus.Instr  = 32'h0022_0020;
        bus.RsData = 32'h1;
        bus.RtData = 32'h2;
        step();
        chk("r0_valid", {31'd0, bus.OpValid}, 32'd1);
        chk("r0_rw",    {31'd0, bus.OpRegWrite}, 32'd0);

        // add $11,$7,$0 with same-edge WB of $7
        bus.Instr      = 32'h00E0_5820;
        bus.RsData     = 32'h1;
        bus.WbRegWrite = 1'b1;
        bus.WbDest     = 5'd7;
        bus.WbData     = 32'hDEAD;
        step();
        chk("wb_opa", bus.OpA, 32'hDEAD);

        // jr $31 does not write; jal writes $31
        quiet_fwd();
        bus.Instr = 32'h03E0_0008;
        step();
        chk("jr_rw", {31'd0, bus.OpRegWrite}, 32'd0);
        bus.Instr = 32'h0C00_0000;
        step();
        chk("jal_rw",   {31'd0, bus.OpRegWrite}, 32'd1);
        chk("jal_dest", {27'd0, bus.OpDest}, 32'd31);

        // lw $8,0($9) then add $10,$8,$8: one stall, bubble, MEM forward
        bus.Instr  = 32'h8D28_0000;
        bus.RsData = 32'h100;
        step();
        chk("lw_mr",   {31'd0, bus.OpMemRead}, 32'd1);
        chk("lw_dest", {27'd0, bus.OpDest}, 32'd8);
        chk("lw_opa",  bus.OpA, 32'h100);
        bus.Instr  = 32'h0108_5020;
        bus.RsData = 32'hBAD;
        bus.RtData = 32'hBAD;
        #1;
        chk("lu_stall", {31'd0, bus.Stall}, 32'd1);
        step();
        chk("lu_bubble", {31'd0, bus.OpValid}, 32'd0);
        chk("lu_bub_mr", {31'd0, bus.OpMemRead}, 32'd0);
        chk("lu_bub_dest", {27'd0, bus.OpDest}, 32'd8);
        chk("lu_stall_end", {31'd0, bus.Stall}, 32'd0);
        bus.MemRegWrite = 1'b1;
        bus.MemDest     = 5'd8;
        bus.MemResult   = 32'h1234;
        step();
        chk("lu_valid", {31'd0, bus.OpValid}, 32'd1);
        chk("lu_opa",   bus.OpA, 32'h1234);
        chk("lu_opb",   bus.OpB, 32'h1234);
        chk("lu_dest",  {27'd0, bus.OpDest}, 32'd10);

        // Flush during a load-use hazard
        quiet_fwd();
        bus.Instr = 32'h8D28_0000;
        step();
        bus.Instr = 32'h0108_5020;
        bus.Flush = 1'b1;
        #1;
        chk("fl_stall", {31'd0, bus.Stall}, 32'd0);
        step();
        chk("fl_valid", {31'd0, bus.OpValid}, 32'd0);
        bus.Flush = 1'b0;

        // Asynchronous reset in the middle of a stall
        bus.Instr = 32'h8D28_0000;
        step();
        bus.Instr = 32'h0108_5020;
        #1;
        chk("ar_pre_stall", {31'd0, bus.Stall}, 32'd1);
        #1;
        Reset = 1'b1;
        #1;
        chk("ar_stall", {31'd0, bus.Stall}, 32'd0);
        chk("ar_valid", {31'd0, bus.OpValid}, 32'd0);
        chk("ar_mr",    {31'd0, bus.OpMemRead}, 32'd0);
        chk("ar_dest",  {27'd0, bus.OpDest}, 32'd0);
        chk("ar_opa",   bus.OpA, 32'd0);
        chk("ar_opb",   bus.OpB, 32'd0);
        chk("ar_instr", bus.OpInstr, 32'd0);
        step();
        Reset = 1'b0;

        // addi $1,$0,5 after reset; $0 ignores a WB to $0
        bus.Instr      = 32'h2001_0005;
        bus.RsData     = 32'h1111;
        bus.RtData     = 32'h22;
        bus.WbRegWrite = 1'b1;
        bus.WbDest     = 5'd0;
        bus.WbData     = 32'hFF;
        step();
        chk("pr_valid", {31'd0, bus.OpValid}, 32'd1);
        chk("pr_opa",   bus.OpA, 32'd0);
        chk("pr_opb",   bus.OpB, 32'h22);
        chk("pr_dest",  {27'd0, bus.OpDest}, 32'd1);
        chk("pr_rw",    {31'd0, bus.OpRegWrite}, 32'd1);
        chk("pr_mr",    {31'd0, bus.OpMemRead}, 32'd0);

        // No valid instruction: bubble
        quiet_fwd();
        bus.InstrValid = 1'b0;
        step();
        chk("iv_bubble", {31'd0, bus.OpValid}, 32'd0);
        chk("iv_hold",   {27'd0, bus.OpDest}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
